// File: rtl/bus_access_seq_if.sv
// Request, beat-data and memory-side signal bundle for bus_access_seq.
// master = CU/memory side, slave = the sequencer.
interface bus_access_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_space;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_take;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              err;
  logic [4:0]        ChipSel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              discard;

  modport master (
    output req_valid, req_space, req_we,
    output req_addr, req_len, wr_data,
    output mem_rdata,
    input  req_ready, wr_take, rd_data,
    input  rd_valid, done, err, ChipSel,
    input  mem_addr, mem_wdata, discard
  );

  modport slave (
    input  req_valid, req_space, req_we,
    input  req_addr, req_len, wr_data,
    input  mem_rdata,
    output req_ready, wr_take, rd_data,
    output rd_valid, done, err, ChipSel,
    output mem_addr, mem_wdata, discard
  );
endinterface

// File: rtl/bus_access_seq.sv
// Multi-beat CODE/DATA/XDATA access sequencer with
// per-space wait states and registered read return.
module bus_access_seq #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int LEN_W     = 3,
  parameter int CODE_WS   = 1,
  parameter int DATA_WS   = 0,
  parameter int XDATA_WS  = 2
) (
  input logic             clk,
  input logic             rst_n,
  bus_access_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_LATCH,
    S_DONE
  } state_e;

  localparam logic [1:0] SP_CODE  = 2'b00;
  localparam logic [1:0] SP_DATA  = 2'b01;
  localparam logic [1:0] SP_XDATA = 2'b10;

  state_e            state_q, state_d;
  logic [1:0]        space_q, space_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvld_q, rvld_d;
  logic [4:0]        cs;
  logic              take;
  logic              illegal;

  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [1:0]        sp,
    input logic [ADDR_W-1:0] b,
    input logic [LEN_W-1:0]  n
  );
    logic [ADDR_W-1:0] a;
    a = b + ADDR_W'(n);
    // DATA is an 8-bit internal space
    if (sp == SP_DATA) a = {{(ADDR_W-8){1'b0}}, a[7:0]};
    return a;
  endfunction

  function automatic logic [7:0] ws_of(input logic [1:0] sp);
    logic [7:0] w;
    w = 8'(CODE_WS);
    if (sp == SP_DATA)  w = 8'(DATA_WS);
    if (sp == SP_XDATA) w = 8'(XDATA_WS);
    return w;
  endfunction

  function automatic logic [4:0] rd_sel(input logic [1:0] sp);
    logic [4:0] s;
    s = 5'b00001;
    if (sp == SP_DATA)  s = 5'b00010;
    if (sp == SP_XDATA) s = 5'b01000;
    return s;
  endfunction

  function automatic logic [4:0] wr_sel(input logic [1:0] sp);
    logic [4:0] s;
    s = rd_sel(sp);
    if (sp == SP_DATA)  s = 5'b00110;
    if (sp == SP_XDATA) s = 5'b11000;
    return s;
  endfunction

  assign illegal = (bus.req_space == 2'b11)
                || (bus.req_len == '0)
                || (int'(bus.req_len) > MAX_BURST)
                || (bus.req_space == SP_CODE && bus.req_we);

  always_comb begin
    state_d = state_q;
    space_d = space_q;
    we_d    = we_q;
    base_d  = base_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    cs      = 5'b00000;
    take    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          space_d = bus.req_space;
          we_d    = bus.req_we;
          base_d  = bus.req_addr;
          len_d   = bus.req_len;
          beat_d  = '0;
          err_d   = illegal;
          if (illegal) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            addr_d  = beat_addr(bus.req_space,
                                bus.req_addr, '0);
          end
        end
      end
      S_SETUP: begin
        cs    = rd_sel(space_q);
        cnt_d = ws_of(space_q);
        if (we_q) begin
          take    = 1'b1;
          wdata_d = bus.wr_data;
        end
        state_d = (ws_of(space_q) != 8'd0) ? S_WAIT
                                           : S_LATCH;
      end
      S_WAIT: begin
        cs = rd_sel(space_q);
        if (cnt_q <= 8'd1) state_d = S_LATCH;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_LATCH: begin
        cs = we_q ? wr_sel(space_q) : rd_sel(space_q);
        if (!we_q) begin
          rdata_d = bus.mem_rdata;
          rvld_d  = 1'b1;
        end
        beat_d = beat_q + 1'b1;
        if (beat_d < len_q) begin
          state_d = S_SETUP;
          addr_d  = beat_addr(space_q, base_q, beat_d);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      space_q <= '0;
      we_q    <= 1'b0;
      base_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      space_q <= space_d;
      we_q    <= we_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.wr_take   = take;
  assign bus.rd_data   = rdata_q;
  assign bus.rd_valid  = rvld_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = (state_q == S_DONE) && err_q;
  assign bus.ChipSel   = cs;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.discard   = (cs == 5'b00000);
endmodule

// File: tb/tb_bus_access_seq.sv
// Bench for bus_access_seq: directed plan plus random
// requests against a cycle-timeline reference model.
module tb_bus_access_seq;
  logic clk;
  logic rst_n;
  int   compared;
  int   mism;
  int   acc;
  int   exp_acc;

  bus_access_seq_if #(
    .ADDR_W(16), .DATA_W(8), .LEN_W(3)
  ) bif ();

  bus_access_seq #(
    .ADDR_W(16), .DATA_W(8), .MAX_BURST(4),
    .LEN_W(3), .CODE_WS(1), .DATA_WS(0),
    .XDATA_WS(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bif.req_valid && bif.req_ready) acc++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input logic [1:0] sp);
    if (sp == 2'd0) return 1;
    if (sp == 2'd1) return 0;
    return 2;
  endfunction

  function automatic logic [4:0] rsel(input logic [1:0] sp);
    if (sp == 2'd0) return 5'b00001;
    if (sp == 2'd1) return 5'b00010;
    return 5'b01000;
  endfunction

  function automatic logic [4:0] wsel(input logic [1:0] sp);
    if (sp == 2'd1) return 5'b00110;
    return 5'b11000;
  endfunction

  function automatic logic [15:0] exp_addr(
    input logic [1:0] sp, input logic [15:0] b,
    input int n);
    int a;
    a = (int'(b) + n) % 65536;
    if (sp == 2'd1) a = a % 256;
    return 16'(a);
  endfunction

  function automatic logic [10:0] obs_vec();
    return {bif.ChipSel, bif.wr_take, bif.rd_valid,
            bif.done, bif.err, bif.discard,
            bif.req_ready};
  endfunction

  function automatic logic [10:0] mk(
    input logic [4:0] cs, input bit take, rv, dn,
    input bit er, input bit rdy);
    return {cs, take, rv, dn, er, (cs == 5'd0), rdy};
  endfunction

  // Called at a negedge with the DUT idle; returns at
  // the negedge of the first idle cycle after done.
  task automatic run_req(
    input logic [1:0] sp, input logic we,
    input logic [15:0] addr, input logic [2:0] len,
    input logic [31:0] wpat, input logic [31:0] rpat,
    input bit hold);
    int  ws, bl, total, n, k;
    bit  legal, rv;
    logic [4:0] cs;
    logic [7:0] rb;
    bif.req_valid = 1'b1;
    bif.req_space = sp;
    bif.req_we    = we;
    bif.req_addr  = addr;
    bif.req_len   = len;
    exp_acc++;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      bif.req_valid = 1'b0;
      bif.req_space = 2'($urandom);
      bif.req_we    = 1'($urandom);
      bif.req_addr  = 16'($urandom);
      bif.req_len   = 3'($urandom);
    end
    legal = (sp != 2'd3) && (len != 0) && (len <= 4)
         && !(sp == 2'd0 && we);
    if (!legal) begin
      check("illegal_done", 32'(obs_vec()),
            32'(mk(5'd0, 0, 0, 1, 1, 0)));
      @(negedge clk);
    end else begin
      ws    = ws_of(sp);
      bl    = 2 + ws;
      total = int'(len) * bl;
      for (int t = 0; t <= total; t++) begin
        n = t / bl;
        k = t % bl;
        if (t < total) begin
          bif.mem_rdata = (k == bl - 1) ?
                          rpat[8*n +: 8] : 8'($urandom);
          bif.wr_data   = (k == 0) ?
                          wpat[8*n +: 8] : 8'($urandom);
          cs = (we && k == bl - 1) ? wsel(sp) : rsel(sp);
          rv = !we && n > 0 && k == 0;
          check($sformatf("ctl t=%0d", t),
                32'(obs_vec()),
                32'(mk(cs, we && k == 0, rv, 0, 0, 0)));
          check($sformatf("addr t=%0d", t),
                32'(bif.mem_addr),
                32'(exp_addr(sp, addr, n)));
          if (we && k >= 1)
            check($sformatf("wdata t=%0d", t),
                  32'(bif.mem_wdata),
                  32'(wpat[8*n +: 8]));
          if (rv) begin
            rb = rpat[8*(n-1) +: 8];
            check($sformatf("rdata t=%0d", t),
                  32'(bif.rd_data), 32'(rb));
          end
        end else begin
          check("done", 32'(obs_vec()),
                32'(mk(5'd0, 0, !we, 1, 0, 0)));
          if (!we) begin
            rb = rpat[8*(int'(len)-1) +: 8];
            check("rdata_last", 32'(bif.rd_data),
                  32'(rb));
          end
        end
        @(negedge clk);
      end
    end
    check("idle_after", 32'(obs_vec()),
          32'(mk(5'd0, 0, 0, 0, 0, 1)));
  endtask

  initial begin
    logic [1:0] sp;
    logic [2:0] ln;
    compared = 0;
    mism     = 0;
    acc      = 0;
    exp_acc  = 0;
    rst_n         = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_space = 2'd0;
    bif.req_we    = 1'b0;
    bif.req_addr  = 16'd0;
    bif.req_len   = 3'd0;
    bif.wr_data   = 8'd0;
    bif.mem_rdata = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ctl", 32'(obs_vec()),
          32'(mk(5'd0, 0, 0, 0, 0, 1)));
    check("rst_addr", 32'(bif.mem_addr), 32'd0);
    check("rst_wdata", 32'(bif.mem_wdata), 32'd0);
    check("rst_rdata", 32'(bif.rd_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req(2'd1, 1'b0, 16'h0030, 3'd1,
            32'h0, 32'h0000005A, 1'b0);
    run_req(2'd2, 1'b1, 16'h1FFF, 3'd2,
            32'h00002211, $urandom, 1'b0);
    run_req(2'd1, 1'b0, 16'h00FE, 3'd4,
            32'h0, $urandom, 1'b0);
    run_req(2'd0, 1'b1, 16'h0100, 3'd1,
            $urandom, $urandom, 1'b0);
    run_req(2'd1, 1'b0, 16'h0010, 3'd0,
            $urandom, $urandom, 1'b0);
    run_req(2'd2, 1'b0, 16'h0010, 3'd5,
            $urandom, $urandom, 1'b0);
    run_req(2'd3, 1'b0, 16'h0010, 3'd1,
            $urandom, $urandom, 1'b0);

    // abort an XDATA read during the WAIT of beat 1
    bif.req_valid = 1'b1;
    bif.req_space = 2'd2;
    bif.req_we    = 1'b0;
    bif.req_addr  = 16'h4000;
    bif.req_len   = 3'd3;
    exp_acc++;
    @(posedge clk);
    @(negedge clk);
    bif.req_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      bif.mem_rdata = 8'($urandom | 1);
      @(negedge clk);
    end
    check("abort_wait", 32'(bif.ChipSel), 32'h08);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ctl", 32'(obs_vec()),
          32'(mk(5'd0, 0, 0, 0, 0, 1)));
    check("abort_addr", 32'(bif.mem_addr), 32'd0);
    check("abort_rdata", 32'(bif.rd_data), 32'd0);
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check($sformatf("abort_quiet t=%0d", t),
            32'(obs_vec()),
            32'(mk(5'd0, 0, 0, 0, 0, 1)));
    end
    run_req(2'd2, 1'b0, 16'hFFFF, 3'd2,
            32'h0, $urandom, 1'b0);

    // req_valid held through busy: one accept per window
    run_req(2'd0, 1'b0, 16'h1234, 3'd1,
            32'h0, $urandom, 1'b1);
    run_req(2'd0, 1'b0, 16'h1234, 3'd1,
            32'h0, $urandom, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sp = 2'($urandom_range(0, 3));
      ln = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 3) != 0 && sp == 2'd3)
        sp = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0)
        ln = 3'($urandom_range(1, 4));
      run_req(sp, 1'($urandom), 16'($urandom), ln,
              $urandom, $urandom, 1'b0);
    end

    @(negedge clk);
    check("accept_count", 32'(acc), 32'(exp_acc));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bus_access_seq.md
# bus_access_seq

Parametrised memory-access sequencer for the MCU51 control unit. It accepts one access request at a time (space, direction, base address, burst length) and drives the chip-select vector, address and write data for each beat. Each space has its own wait-state count, and read bytes are returned with a one-cycle valid pulse. It sits between the CU address decode and the CODE/DATA/XDATA memories, replacing fixed per-state chip-select decode with a handshaked, multi-cycle, multi-beat sequence.

## Interface
Parameters:
- ADDR_W, 16, external address width (CODE/XDATA)
- DATA_W, 8, data width
- MAX_BURST, 4, maximum beats per request (≥1)
- LEN_W, 3, width of req_len; must hold MAX_BURST
- CODE_WS, 1, wait cycles per CODE beat
- DATA_WS, 0, wait cycles per DATA beat
- XDATA_WS, 2, wait cycles per XDATA beat

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready
- req_space  in  2  00 CODE, 01 DATA, 10 XDATA, 11 reserved
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  base address
- req_len  in  LEN_W  beat count, legal range 1..MAX_BURST
- wr_data  in  DATA_W  write byte for the current beat
- wr_take  out  1  one-cycle pulse: wr_data sampled this cycle
- rd_data  out  DATA_W  registered read byte
- rd_valid  out  1  one-cycle pulse: rd_data holds a new byte
- done  out  1  one-cycle pulse at end of request
- err  out  1  high with done when the request was illegal
- ChipSel  out  5  {XDATA_W,XDATA_CS,DATA_W,DATA_CS,CODE_CS}
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data
- discard  out  1  high when ChipSel == 00000 (no access in flight; PC must not advance)

## Operation
- States: IDLE, SETUP, WAIT, LATCH, DONE.
- IDLE: req_ready=1. On accept, latch space, we, addr, len and check legality:
  - illegal = space==11, len==0, len>MAX_BURST, or (space==CODE & we);
  - illegal goes to DONE with err=1 and no ChipSel activity;
  - legal goes to SETUP with beat=0.
- SETUP (1 cycle):
  - mem_addr = base+beat; DATA space forces the upper ADDR_W-8 bits to 0 and wraps mod 256; CODE/XDATA wrap mod 2^ADDR_W.
  - ChipSel = read select for the space: CODE 00001, DATA 00010, XDATA 01000.
  - For writes, wr_take=1 and wr_data is registered into mem_wdata.
  - Load wait counter with the space's WS; next state is WAIT if WS>0, else LATCH.
- WAIT: ChipSel and mem_addr held; counter decrements; go to LATCH when it reaches 1.
- LATCH (1 cycle):
  - Read: mem_rdata is captured into rd_data at the end of the cycle, and rd_valid=1 in the following cycle.
  - Write: ChipSel = write select (DATA 00110, XDATA 11000) in this cycle only.
  - beat++. Next state is SETUP if beat<len, else DONE.
- DONE (1 cycle): done=1, err as latched, ChipSel=00000; return to IDLE.
- ChipSel is 00000 in IDLE and DONE, and discard tracks it.

## Timing
- Beat length = 2 + WS cycles.
- Legal request accepted at edge E: SETUP of beat 0 starts at E. Total busy time is len*(2+WS) cycles, then done is high for 1 cycle; req_ready is high again the cycle after done.
- Illegal request: done=err=1 in the cycle after the accept edge.
- rd_valid for beat n falls in the SETUP cycle of beat n+1, or in DONE for the last beat.
- req_* are ignored outside IDLE and need not be held after acceptance.
- Reset values: state IDLE, req_ready=1, ChipSel=00000, discard=1, mem_addr=0, mem_wdata=0, rd_data=0, rd_valid=0, wr_take=0, done=0, err=0.
- rst_n low mid-burst aborts the request: the next edge forces IDLE and reset values, and no done is issued.
- rd_valid is registered, so with DATA_WS=0 and back-to-back beats it pulses every 2 cycles, never stretched.

## Test plan
- DATA read, addr 0x0030, len 1, DATA_WS=0, mem_rdata=0x5A:
  - ChipSel=00010 for 2 cycles, then rd_data=0x5A with rd_valid for 1 cycle, then done.
  - Total 3 cycles from accept.
- XDATA write, addr 0x1FFF, len 2, wr_data 0x11/0x22, XDATA_WS=2:
  - Two beats of 4 cycles each, mem_addr 0x1FFF then 0x2000.
  - ChipSel=11000 only in each LATCH cycle; mem_wdata 0x11 then 0x22; two wr_take pulses.
- DATA read, addr 0x00FE, len 4:
  - mem_addr sequence 0x00FE, 0x00FF, 0x0000, 0x0001 (wrap mod 256); four rd_valid pulses.
- Illegal requests, each in turn: CODE write, len 0, len 5, space 11:
  - done=err=1 one cycle after accept; ChipSel stays 00000; discard stays 1.
- rst_n low during WAIT of beat 1 of an XDATA read, len 3:
  - Next edge gives ChipSel=00000, req_ready=1, and no done/rd_valid pulse.
  - A new request is accepted normally afterwards.
- CODE read, len 1, CODE_WS=1: CS held 3 cycles; req_valid held high through busy gives exactly one acceptance per req_ready window.
